// File: rtl/food_eat_detector_if.sv
// -----------------------------------------------------------------------------
// food_eat_detector_if
//   Pixel-scan / sprite-region bus between the VGA pixel generator, the sprite
//   renderers and the food eat detector, plus the eaten_n strobe returned to
//   the food sprite.
//
//   pixel_tick     one-clk strobe marking a valid pixel_x/pixel_y
//   pixel_x        x of the current pixel (0..639)
//   pixel_y        y of the current pixel (0..479)
//   food_region    food sprite covers the current pixel
//   player_region  player sprite covers the current pixel
//   eaten_n        active-HIGH one-clk pulse: food eaten (to food sprite)
//
//   master: pixel/sprite side (drives scan and regions, receives eaten_n)
//   slave : detector side
// -----------------------------------------------------------------------------
interface food_eat_detector_if;
   logic       pixel_tick;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       food_region;
   logic       player_region;
   logic       eaten_n;

   modport master (
      output pixel_tick, pixel_x, pixel_y, food_region, player_region,
      input  eaten_n
   );

   modport slave (
      input  pixel_tick, pixel_x, pixel_y, food_region, player_region,
      output eaten_n
   );
endinterface

// File: rtl/food_eat_detector.sv
// -----------------------------------------------------------------------------
// food_eat_detector
//   Counts pixels where the food and player sprites overlap during a frame.
//   At the next frame start it decides whether the food was eaten, pulses
//   eaten_n for one clock, and updates score, per-level food count and the
//   level-clear flag. After an eat, whole frames are ignored while the food
//   relocates.
//
//   clk          system clock
//   reset_n      asynchronous, active-low reset
//   enable       1 = game running; 0 = detection off
//   level        current level (0..15)
//   bus          pixel scan / sprite regions in, eaten_n out (slave modport)
//   score        accumulated score, saturating at all-ones
//   food_count   foods eaten in the current level
//   level_clear  high once food_count reaches FOODS_PER_LEVEL
// -----------------------------------------------------------------------------
module food_eat_detector #(
   parameter int unsigned FOODS_PER_LEVEL = 8,
   parameter int unsigned MIN_OVERLAP     = 4,
   parameter int unsigned COOLDOWN_FRAMES = 2,
   parameter int unsigned SCORE_W         = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic [3:0]            level,
   food_eat_detector_if.slave    bus,
   output logic [SCORE_W-1:0]    score,
   output logic [3:0]            food_count,
   output logic                  level_clear
);

   typedef enum logic [1:0] {ARMED, COOL, CLEAR} state_e;

   localparam logic [9:0] MIN_OVL   = 10'(MIN_OVERLAP);
   localparam logic [3:0] FPL       = 4'(FOODS_PER_LEVEL);
   localparam logic [3:0] COOL_INIT = 4'(COOLDOWN_FRAMES);

   state_e             state_q, state_d;
   logic [9:0]         ovl_cnt_q, ovl_cnt_d;
   logic [3:0]         cool_cnt_q, cool_cnt_d;
   logic [3:0]         level_q, level_d;
   logic               level_vld_q, level_vld_d;
   logic               eaten_q, eaten_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [3:0]         food_count_q, food_count_d;
   logic               level_clear_q, level_clear_d;

   logic               frame_start;
   logic               hit_px;
   logic               level_chg;
   logic [SCORE_W:0]   score_sum;
   logic [3:0]         food_inc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ARMED;
         ovl_cnt_q     <= '0;
         cool_cnt_q    <= '0;
         level_q       <= '0;
         level_vld_q   <= 1'b0;
         eaten_q       <= 1'b0;
         score_q       <= '0;
         food_count_q  <= '0;
         level_clear_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ovl_cnt_q     <= ovl_cnt_d;
         cool_cnt_q    <= cool_cnt_d;
         level_q       <= level_d;
         level_vld_q   <= level_vld_d;
         eaten_q       <= eaten_d;
         score_q       <= score_d;
         food_count_q  <= food_count_d;
         level_clear_q <= level_clear_d;
      end
   end

   always_comb begin
      frame_start = bus.pixel_tick && (bus.pixel_x == '0) && (bus.pixel_y == '0);
      hit_px      = bus.pixel_tick && bus.food_region && bus.player_region && !frame_start;
      // level_q is only meaningful once captured after reset release
      level_chg   = level_vld_q && (level != level_q);
      score_sum   = {1'b0, score_q} + (SCORE_W+1)'(level_q) + (SCORE_W+1)'(1);
      food_inc    = food_count_q + 4'd1;

      state_d       = state_q;
      ovl_cnt_d     = ovl_cnt_q;
      cool_cnt_d    = cool_cnt_q;
      level_vld_d   = 1'b1;
      level_d       = level_vld_q ? level_q : level;
      eaten_d       = 1'b0;
      score_d       = score_q;
      food_count_d  = food_count_q;
      level_clear_d = level_clear_q;

      if (!enable) begin
         // Level changes seen while disabled are applied once re-enabled.
         state_d    = ARMED;
         ovl_cnt_d  = '0;
         cool_cnt_d = '0;
      end else if (level_chg) begin
         level_d       = level;
         food_count_d  = '0;
         level_clear_d = 1'b0;
         ovl_cnt_d     = '0;
         cool_cnt_d    = '0;
         state_d       = ARMED;
      end else begin
         if (frame_start) begin
            ovl_cnt_d = '0;
         end
         unique case (state_q)
            ARMED: begin
               if (frame_start) begin
                  if (ovl_cnt_q >= MIN_OVL) begin
                     eaten_d      = 1'b1;
                     score_d      = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                     food_count_d = food_inc;
                     if (food_inc == FPL) begin
                        level_clear_d = 1'b1;
                        state_d       = CLEAR;
                     end else begin
                        cool_cnt_d = COOL_INIT;
                        state_d    = COOL;
                     end
                  end
               end else if (hit_px && (ovl_cnt_q != '1)) begin
                  ovl_cnt_d = ovl_cnt_q + 10'd1;
               end
            end
            COOL: begin
               // The frame whose start empties the cooldown is already counted.
               if (frame_start) begin
                  cool_cnt_d = cool_cnt_q - 4'd1;
                  if (cool_cnt_q == 4'd1) begin
                     state_d = ARMED;
                  end
               end
            end
            CLEAR: begin
            end
            default: state_d = ARMED;
         endcase
      end
   end

   assign bus.eaten_n  = eaten_q;
   assign score        = score_q;
   assign food_count   = food_count_q;
   assign level_clear  = level_clear_q;

endmodule

// File: tb/tb_food_eat_detector.sv
module tb_food_eat_detector;

   localparam int FPL    = 8;
   localparam int MINOVL = 4;
   localparam int COOLF  = 2;
   localparam int SW     = 8;
   localparam int SMAX   = (1 << SW) - 1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          enable = 1'b0;
   logic [3:0]    level = '0;
   logic [SW-1:0] score;
   logic [3:0]    food_count;
   logic          level_clear;

   food_eat_detector_if bus();

   food_eat_detector #(
      .FOODS_PER_LEVEL (FPL),
      .MIN_OVERLAP     (MINOVL),
      .COOLDOWN_FRAMES (COOLF),
      .SCORE_W         (SW)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .level       (level),
      .bus         (bus),
      .score       (score),
      .food_count  (food_count),
      .level_clear (level_clear)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Frame-level reference model: overlap pixels this frame, frames still to
   // skip after an eat, and whether the level is finished.
   int m_ovl, m_skip, m_food, m_score, m_lvl;
   bit m_blocked, m_clear, m_pulse, m_lvl_known;

   function automatic void model_reset();
      m_ovl = 0; m_skip = 0; m_food = 0; m_score = 0; m_lvl = 0;
      m_blocked = 0; m_clear = 0; m_pulse = 0; m_lvl_known = 0;
   endfunction

   function automatic void model_step(input bit en, input bit t, input int x, input int y,
                                      input bit f, input bit p, input int lvl);
      bit fs;
      bit lchg;
      fs = t && (x == 0) && (y == 0);
      lchg = 0;
      m_pulse = 0;
      if (!m_lvl_known) begin
         m_lvl = lvl;
         m_lvl_known = 1;
      end else begin
         lchg = (lvl != m_lvl);
      end
      if (!en) begin
         m_ovl = 0; m_skip = 0; m_blocked = 0;
      end else if (lchg) begin
         m_lvl = lvl; m_food = 0; m_clear = 0; m_ovl = 0; m_skip = 0; m_blocked = 0;
      end else if (fs) begin
         if (m_blocked) begin
         end else if (m_skip > 0) begin
            m_skip--;
         end else if (m_ovl >= MINOVL) begin
            m_pulse = 1;
            m_score = m_score + m_lvl + 1;
            if (m_score > SMAX) m_score = SMAX;
            m_food = (m_food + 1) % 16;
            if (m_food == FPL) begin
               m_clear = 1; m_blocked = 1;
            end else begin
               m_skip = COOLF;
            end
         end
         m_ovl = 0;
      end else if (t && f && p && !m_blocked && m_skip == 0) begin
         if (m_ovl < 1023) m_ovl++;
      end
   endfunction

   int fs_n = 0;
   int pulse_fs[$];

   task automatic cycle(input bit t, input int x, input int y, input bit f, input bit p);
      bus.pixel_tick    = t;
      bus.pixel_x       = x[9:0];
      bus.pixel_y       = y[9:0];
      bus.food_region   = f;
      bus.player_region = p;
      if (t && x == 0 && y == 0) fs_n++;
      model_step(enable, t, x, y, f, p, int'(level));
      @(posedge clk);
      #1;
      check("eaten_n", int'(bus.eaten_n), int'(m_pulse));
      check("score", int'(score), m_score);
      check("food_count", int'(food_count), m_food);
      check("level_clear", int'(level_clear), int'(m_clear));
      if (bus.eaten_n === 1'b1) pulse_fs.push_back(fs_n);
   endtask

   task automatic idle();
      cycle(0, 5, 5, 0, 0);
   endtask

   task automatic do_fs();
      cycle(1, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   // n overlapping ticks mixed with ignored/non-overlapping pixels
   task automatic hits(input int n);
      for (int i = 0; i < n; i++) begin
         cycle(1, $urandom_range(1, 639), $urandom_range(0, 479), 1, 1);
         cycle(0, 0, 0, 1, 1);
         cycle(1, $urandom_range(1, 639), $urandom_range(0, 479), 1, 0);
      end
   endtask

   task automatic eat_one();
      hits(5);
      do_fs();
      do_fs();
      do_fs();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #2;
      check("rst_eaten_n", int'(bus.eaten_n), 0);
      check("rst_score", int'(score), 0);
      check("rst_food_count", int'(food_count), 0);
      check("rst_level_clear", int'(level_clear), 0);
      model_reset();
      pulse_fs.delete();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      int gap;
      bus.pixel_tick = 0; bus.pixel_x = '0; bus.pixel_y = '0;
      bus.food_region = 0; bus.player_region = 0;
      @(posedge clk);
      #1;

      // 6 overlaps at level 0 -> one pulse after the next frame start
      enable = 1; level = 0;
      do_reset();
      idle();
      do_fs();
      hits(6);
      do_fs();
      check("s1_pulse", int'(bus.eaten_n), 1);
      check("s1_score", int'(score), 1);
      check("s1_food", int'(food_count), 1);
      idle();
      check("s1_pulse_width", int'(bus.eaten_n), 0);

      // 3 overlaps: below threshold
      do_reset();
      idle();
      hits(3);
      do_fs();
      check("s2_no_pulse", int'(bus.eaten_n), 0);
      check("s2_score", int'(score), 0);
      hits(1);
      do_fs();
      check("s2_ovl_cleared", int'(bus.eaten_n), 0);

      // overlap held for 5 frames -> 2 pulses, 3 frame starts apart
      do_reset();
      idle();
      for (int k = 0; k < 5; k++) begin
         do_fs();
         hits(6);
      end
      do_fs();
      check("s3_pulses", pulse_fs.size(), 2);
      gap = (pulse_fs.size() >= 2) ? pulse_fs[1] - pulse_fs[0] : -1;
      check("s3_gap", gap, 3);

      // level 3: 8 foods -> score 32, cleared, then level change
      do_reset();
      level = 3;
      idle();
      repeat (8) eat_one();
      check("s4_score", int'(score), 32);
      check("s4_clear", int'(level_clear), 1);
      check("s4_food", int'(food_count), 8);
      hits(6);
      do_fs();
      check("s4_no_pulse_clear", int'(bus.eaten_n), 0);
      level = 4;
      idle();
      check("s4_lvl_food", int'(food_count), 0);
      check("s4_lvl_clear", int'(level_clear), 0);
      check("s4_lvl_score", int'(score), 32);

      // score saturation: 128 + 120 + 6 = 254, then +3 saturates
      do_reset();
      level = 15; idle();
      repeat (8) eat_one();
      level = 14; idle();
      repeat (8) eat_one();
      level = 5; idle();
      eat_one();
      check("s5_score254", int'(score), 254);
      level = 2; idle();
      eat_one();
      check("s5_score_sat", int'(score), 255);

      // enable low at the deciding frame start suppresses the pulse
      do_reset();
      level = 0; idle();
      hits(5);
      enable = 0;
      do_fs();
      check("s7_dis_pulse", int'(bus.eaten_n), 0);
      enable = 1;
      hits(5);
      do_fs();
      check("s7_en_pulse", int'(bus.eaten_n), 1);

      // reset mid-cooldown, no cooldown carried over
      do_reset();
      idle();
      hits(5);
      do_fs();
      do_fs();
      do_reset();
      idle();
      hits(5);
      do_fs();
      check("s6_pulse", int'(bus.eaten_n), 1);

      // randomized frames against the model
      do_reset();
      enable = 1;
      for (int fr = 0; fr < 250; fr++) begin
         if ($urandom_range(0, 19) == 0) level = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 11) == 0) enable = ($urandom_range(0, 3) != 0);
         do_fs();
         for (int i = 0; i < int'($urandom_range(2, 10)); i++) begin
            if ($urandom_range(0, 29) == 0)
               cycle(1'($urandom_range(0, 1)), 0, 0, 1, 1);
            else
               cycle($urandom_range(0, 3) != 0, $urandom_range(0, 639), $urandom_range(0, 479),
                     $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
